// File: rtl/vga_pll_lock_supervisor.sv
// ----------------------------------------------------------------------------
// vga_pll_lock_supervisor
//
// Controls the VGA video PLL and supervises its lock. The PLL is held in reset
// for a fixed time, then the supervisor waits for a synchronized lock
// indication. Lock must then stay stable for a programmed number of cycles
// before the VGA subsystem is released from reset. A lock timeout retries the
// PLL; once the retry budget is exhausted the block parks in FAULT until
// software asks for a relock. Loss of lock while running re-runs the sequence.
//
// Ports
//   clk             in   50 MHz reference clock (same net as the PLL refclk)
//   reset_n         in   synchronous, active-low reset
//   pll_locked      in   PLL locked indication, asynchronous to clk
//   relock_req      in   single-cycle pulse forcing a fresh reset/lock sequence
//   pll_rst         out  PLL reset, active high
//   sys_reset_n     out  VGA controller/pixel logic reset, active low
//   lock_lost_pulse out  one-cycle pulse when lock drops while running
//   fault           out  high while in FAULT
//   retry_count     out  failed attempts in the current sequence (saturating)
//   state           out  debug state: 0 PLL_RST, 1 WAIT_LOCK, 2 STABLE,
//                        3 RUN, 4 FAULT
// ----------------------------------------------------------------------------
module vga_pll_lock_supervisor #(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned CNT_W               = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_reset_n,
  output logic       lock_lost_pulse,
  output logic       fault,
  output logic [1:0] retry_count,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRIES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1_q, sync1_d;
  logic             lk_q, lk_d;            // second synchronizer stage = lk
  logic             pll_rst_q, pll_rst_d;
  logic             sys_reset_n_q, sys_reset_n_d;
  logic             fault_q, fault_d;
  logic             lock_lost_pulse_q, lock_lost_pulse_d;
  logic [1:0]       retry_count_q, retry_count_d;
  logic [1:0]       retry_inc_s;

  // Next-state, counter, synchronizer and registered-output computation.
  always_comb begin
    state_d           = state_q;
    retry_count_d     = retry_count_q;
    lock_lost_pulse_d = 1'b0;
    sync1_d           = pll_locked;
    lk_d              = sync1_q;

    if (retry_count_q == RETRY_MAX) begin
      retry_inc_s = retry_count_q;
    end else begin
      retry_inc_s = retry_count_q + 2'd1;
    end

    case (state_q)
      ST_PLL_RST: begin
        // relock_req has no effect here: the PLL is already being reset.
        if (cnt_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
        end else begin
          state_d = ST_PLL_RST;
        end
      end
      ST_WAIT_LOCK: begin
        if (relock_req) begin
          state_d = ST_PLL_RST;
        end else if (lk_q) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retry_count_d = retry_inc_s;
          if (retry_inc_s == RETRY_MAX) begin
            state_d = ST_FAULT;
          end else begin
            state_d = ST_PLL_RST;
          end
        end else begin
          state_d = ST_WAIT_LOCK;
        end
      end
      ST_STABLE: begin
        if (relock_req) begin
          state_d = ST_PLL_RST;
        end else if (!lk_q) begin
          // A glitch in lock restarts the timeout window, not a retry.
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d       = ST_RUN;
          retry_count_d = 2'd0;
        end else begin
          state_d = ST_STABLE;
        end
      end
      ST_RUN: begin
        if (!lk_q) begin
          // Lock loss wins the pulse even when a relock is requested too.
          state_d           = ST_PLL_RST;
          lock_lost_pulse_d = 1'b1;
        end else if (relock_req) begin
          state_d = ST_PLL_RST;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FAULT: begin
        if (relock_req) begin
          state_d       = ST_PLL_RST;
          retry_count_d = 2'd0;
        end else begin
          state_d = ST_FAULT;
        end
      end
      default: begin
        state_d       = ST_PLL_RST;
        retry_count_d = 2'd0;
      end
    endcase

    // Counter restarts on every state change; saturates rather than wraps
    // during the long-lived RUN/FAULT states.
    if (state_d != state_q) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q == {CNT_W{1'b1}}) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Outputs are decoded from the next state so they line up with state.
    pll_rst_d     = (state_d == ST_PLL_RST);
    sys_reset_n_d = (state_d == ST_RUN);
    fault_d       = (state_d == ST_FAULT);
  end

  // State, counter, synchronizer and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q           <= ST_PLL_RST;
      cnt_q             <= {CNT_W{1'b0}};
      sync1_q           <= 1'b0;
      lk_q              <= 1'b0;
      pll_rst_q         <= 1'b1;
      sys_reset_n_q     <= 1'b0;
      fault_q           <= 1'b0;
      lock_lost_pulse_q <= 1'b0;
      retry_count_q     <= 2'd0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      sync1_q           <= sync1_d;
      lk_q              <= lk_d;
      pll_rst_q         <= pll_rst_d;
      sys_reset_n_q     <= sys_reset_n_d;
      fault_q           <= fault_d;
      lock_lost_pulse_q <= lock_lost_pulse_d;
      retry_count_q     <= retry_count_d;
    end
  end

  assign pll_rst         = pll_rst_q;
  assign sys_reset_n     = sys_reset_n_q;
  assign lock_lost_pulse = lock_lost_pulse_q;
  assign fault           = fault_q;
  assign retry_count     = retry_count_q;
  assign state           = state_q;

endmodule

// File: tb/tb_vga_pll_lock_supervisor.sv
// ----------------------------------------------------------------------------
// tb_vga_pll_lock_supervisor
//
// Directed bench for vga_pll_lock_supervisor with small parameters
// (PLL reset 4, timeout 20, stable 8, max retries 2). Inputs change 1 time
// unit after a rising edge and outputs are checked at that same point.
// ----------------------------------------------------------------------------
module tb_vga_pll_lock_supervisor;

  logic       clk;
  logic       reset_n;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic       sys_reset_n;
  logic       lock_lost_pulse;
  logic       fault;
  logic [1:0] retry_count;
  logic [2:0] state;

  int n_cmp;
  int n_err;

  vga_pll_lock_supervisor #(
    .PLL_RST_CYCLES     (4),
    .LOCK_TIMEOUT_CYCLES(20),
    .LOCK_STABLE_CYCLES (8),
    .MAX_RETRIES        (2),
    .CNT_W              (16)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pll_locked     (pll_locked),
    .relock_req     (relock_req),
    .pll_rst        (pll_rst),
    .sys_reset_n    (sys_reset_n),
    .lock_lost_pulse(lock_lost_pulse),
    .fault          (fault),
    .retry_count    (retry_count),
    .state          (state)
  );

  // 10-unit reference clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_pll_rst"}, 32'(pll_rst), 32'd1);
    chk({tag, "_sys_reset_n"}, 32'(sys_reset_n), 32'd0);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
    chk({tag, "_lock_lost"}, 32'(lock_lost_pulse), 32'd0);
    chk({tag, "_retry"}, 32'(retry_count), 32'd0);
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    reset_n    = 1'b0;
    pll_locked = 1'b1;
    relock_req = 1'b0;

    // ---- 1: power-up with lock present from cycle 0
    tick();
    tick();
    chk_reset_vals("rst");
    reset_n = 1'b1;
    tick();
    chk("t1_rst_c1", 32'(state), 32'd0);
    chk("t1_pllrst_c1", 32'(pll_rst), 32'd1);
    tick();
    tick();
    chk("t1_rst_c3", 32'(state), 32'd0);
    chk("t1_pllrst_c3", 32'(pll_rst), 32'd1);
    tick();
    chk("t1_wait", 32'(state), 32'd1);
    chk("t1_pllrst_low", 32'(pll_rst), 32'd0);
    tick();
    chk("t1_stable", 32'(state), 32'd2);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("t1_stable_hold", 32'(state), 32'd2);
      chk("t1_sysrst_hold", 32'(sys_reset_n), 32'd0);
    end
    tick();
    chk("t1_run", 32'(state), 32'd3);
    chk("t1_sysrst_rel", 32'(sys_reset_n), 32'd1);
    chk("t1_retry", 32'(retry_count), 32'd0);

    // ---- 4: lock lost in RUN, seen after the synchronizer
    pll_locked = 1'b0;
    tick();
    chk("t4_sync1", 32'(state), 32'd3);
    tick();
    chk("t4_sync2", 32'(state), 32'd3);
    chk("t4_sync2_sys", 32'(sys_reset_n), 32'd1);
    tick();
    chk("t4_state", 32'(state), 32'd0);
    chk("t4_pulse", 32'(lock_lost_pulse), 32'd1);
    chk("t4_sysrst", 32'(sys_reset_n), 32'd0);
    chk("t4_pllrst", 32'(pll_rst), 32'd1);
    tick();
    chk("t4_pulse_once", 32'(lock_lost_pulse), 32'd0);
    chk("t4_pllrst2", 32'(pll_rst), 32'd1);
    tick();
    tick();
    chk("t4_pllrst4", 32'(pll_rst), 32'd1);
    tick();
    chk("t4_wait", 32'(state), 32'd1);
    chk("t4_pllrst_low", 32'(pll_rst), 32'd0);

    // ---- 2: no lock -> two timeouts -> FAULT, then relock_req
    repeat (19) tick();
    chk("t2_to1_before", 32'(state), 32'd1);
    chk("t2_retry0", 32'(retry_count), 32'd0);
    tick();
    chk("t2_to1", 32'(state), 32'd0);
    chk("t2_retry1", 32'(retry_count), 32'd1);
    repeat (3) tick();
    chk("t2_rst_hold", 32'(state), 32'd0);
    tick();
    chk("t2_wait2", 32'(state), 32'd1);
    repeat (19) tick();
    chk("t2_to2_before", 32'(state), 32'd1);
    chk("t2_retry1b", 32'(retry_count), 32'd1);
    tick();
    chk("t2_fault_state", 32'(state), 32'd4);
    chk("t2_fault", 32'(fault), 32'd1);
    chk("t2_retry2", 32'(retry_count), 32'd2);
    chk("t2_pllrst", 32'(pll_rst), 32'd0);
    chk("t2_sysrst", 32'(sys_reset_n), 32'd0);
    pll_locked = 1'b1;
    repeat (4) tick();
    chk("t2_fault_ignores_lk", 32'(state), 32'd4);
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    chk("t2_relock_state", 32'(state), 32'd0);
    chk("t2_relock_fault", 32'(fault), 32'd0);
    chk("t2_relock_retry", 32'(retry_count), 32'd0);
    chk("t2_relock_pllrst", 32'(pll_rst), 32'd1);

    // ---- 5b: relock_req during PLL_RST is ignored
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    chk("t5b_ignored", 32'(state), 32'd0);
    tick();
    tick();
    chk("t5b_width", 32'(pll_rst), 32'd1);
    tick();
    chk("t5b_wait", 32'(state), 32'd1);

    // ---- 3: one-cycle lock dip in STABLE at cnt=5
    tick();
    chk("t3_stable", 32'(state), 32'd2);
    repeat (3) tick();
    chk("t3_cnt3", 32'(state), 32'd2);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    chk("t3_cnt5", 32'(state), 32'd2);
    tick();
    chk("t3_back_wait", 32'(state), 32'd1);
    chk("t3_sysrst", 32'(sys_reset_n), 32'd0);
    chk("t3_retry", 32'(retry_count), 32'd0);
    tick();
    chk("t3_restable", 32'(state), 32'd2);
    repeat (7) tick();
    chk("t3_full_count", 32'(state), 32'd2);
    chk("t3_full_sysrst", 32'(sys_reset_n), 32'd0);
    tick();
    chk("t3_run", 32'(state), 32'd3);
    chk("t3_run_sysrst", 32'(sys_reset_n), 32'd1);

    // ---- 5: relock_req alone in RUN -> PLL_RST without pulse
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    chk("t5_relock_state", 32'(state), 32'd0);
    chk("t5_relock_pulse", 32'(lock_lost_pulse), 32'd0);
    chk("t5_relock_sysrst", 32'(sys_reset_n), 32'd0);
    repeat (4) tick();
    chk("t5_wait", 32'(state), 32'd1);
    tick();
    chk("t5_stable", 32'(state), 32'd2);
    repeat (7) tick();
    chk("t5_stable_end", 32'(state), 32'd2);
    tick();
    chk("t5_run", 32'(state), 32'd3);

    // ---- 5: relock_req coincident with lk falling in RUN
    pll_locked = 1'b0;
    tick();
    tick();
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    chk("t5c_state", 32'(state), 32'd0);
    chk("t5c_pulse", 32'(lock_lost_pulse), 32'd1);
    chk("t5c_sysrst", 32'(sys_reset_n), 32'd0);
    chk("t5c_pllrst", 32'(pll_rst), 32'd1);
    tick();
    chk("t5c_pulse_once", 32'(lock_lost_pulse), 32'd0);

    // ---- 6: reset_n pulse mid-WAIT_LOCK
    repeat (3) tick();
    chk("t6_wait", 32'(state), 32'd1);
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk_reset_vals("t6_rst");
    repeat (3) tick();
    chk("t6_cnt_restart", 32'(state), 32'd0);
    chk("t6_pllrst", 32'(pll_rst), 32'd1);
    tick();
    chk("t6_wait_again", 32'(state), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
